// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch elapsed-time datapath.
// Times are packed as {M10, M1, S10, S1}, one BCD digit per nibble.
package stopwatch_pkg;

    localparam int unsigned BCD_W            = 4;
    localparam int unsigned TIME_W           = 4 * BCD_W;
    localparam int unsigned TICK_DIV_DEFAULT = 100_000_000;

    localparam logic [BCD_W-1:0] SEC_ONES_MAX = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] MIN_ONES_MAX = 4'd9;
    localparam logic [BCD_W-1:0] MIN_TENS_MAX = 4'd5;

    localparam logic [TIME_W-1:0] MAX_TIME = 16'h5959;

    // Next value of one digit; anything at or above max rolls to zero so an
    // out-of-range digit can never persist.
    function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] q,
                                                  input logic [BCD_W-1:0] max,
                                                  input logic             en);
        logic [BCD_W-1:0] r;
        r = q;
        if (en) begin
            r = (q >= max) ? '0 : q + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the elapsed-time chain: counts 0..MAX, carries out when
// enabled while sitting at MAX.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = 4'd9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    logic [BCD_W-1:0] q_q, q_d;

    always_comb begin
        q_d = bcd_next(q_q, MAX, en);
        if (clr) begin
            q_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = en && (q_q == MAX);

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD elapsed-time counter with a 1 s prescaler and a freezable
// display register for lap mode.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter bit          WRAP_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              count_en,
    input  logic              count_reset,
    input  logic              freeze_en,
    output logic [TIME_W-1:0] live_bcd,
    output logic [TIME_W-1:0] disp_bcd,
    output logic              frozen,
    output logic              sec_tick,
    output logic              at_max
);

    localparam int unsigned      PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic              tick_q, tick_d;
    logic              frozen_q, frozen_d;
    logic [TIME_W-1:0] disp_q, disp_d;
    logic [TIME_W-1:0] live_d;

    logic              adv;
    logic [3:0]        dig_en;
    logic [3:0]        carry;
    logic [BCD_W-1:0]  s1_q, s10_q, m1_q, m10_q;
    logic              unused_rollover;

    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (count_en) begin
            if (presc_q == LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        if (count_reset) begin
            presc_d = '0;
            tick_d  = 1'b0;
        end
    end

    // Saturating build drops ticks at 59:59 while the prescaler keeps running.
    assign adv    = tick_d && !(at_max && !WRAP_EN);
    assign dig_en = {carry[2:0], adv};

    bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (count_reset),
        .en    (dig_en[0]),
        .q     (s1_q),
        .carry (carry[0])
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (count_reset),
        .en    (dig_en[1]),
        .q     (s10_q),
        .carry (carry[1])
    );

    bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (count_reset),
        .en    (dig_en[2]),
        .q     (m1_q),
        .carry (carry[2])
    );

    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (count_reset),
        .en    (dig_en[3]),
        .q     (m10_q),
        .carry (carry[3])
    );

    assign unused_rollover = carry[3];

    // Value the digit chain loads on this edge, so the display can track it.
    always_comb begin
        live_d = {bcd_next(m10_q, MIN_TENS_MAX, dig_en[3]),
                  bcd_next(m1_q,  MIN_ONES_MAX, dig_en[2]),
                  bcd_next(s10_q, SEC_TENS_MAX, dig_en[1]),
                  bcd_next(s1_q,  SEC_ONES_MAX, dig_en[0])};
        if (count_reset) begin
            live_d = '0;
        end
    end

    always_comb begin
        frozen_d = freeze_en;
        disp_d   = freeze_en ? disp_q : live_d;
        if (count_reset) begin
            disp_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= '0;
            tick_q   <= 1'b0;
            frozen_q <= 1'b0;
            disp_q   <= '0;
        end else begin
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            frozen_q <= frozen_d;
            disp_q   <= disp_d;
        end
    end

    assign live_bcd = {m10_q, m1_q, s10_q, s1_q};
    assign disp_bcd = disp_q;
    assign frozen   = frozen_q;
    assign sec_tick = tick_q;
    assign at_max   = (live_bcd == MAX_TIME);

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench: a seconds-based model pushes expected outputs per cycle for
// a wrapping and a saturating instance; they are popped after each clock edge.
module tb_stopwatch_counter;

    localparam int unsigned TD = 4;

    typedef struct packed {
        logic [15:0] live;
        logic [15:0] disp;
        logic        frozen;
        logic        tick;
        logic        at_max;
    } exp_t;

    logic clk = 1'b0;
    logic reset, count_en, count_reset, freeze_en;

    logic [15:0] live_w, disp_w, live_s, disp_s;
    logic        frozen_w, tick_w, at_max_w, frozen_s, tick_s, at_max_s;

    always #5 clk = ~clk;

    stopwatch_counter #(.TICK_DIV(TD), .WRAP_EN(1'b1)) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .count_en    (count_en),
        .count_reset (count_reset),
        .freeze_en   (freeze_en),
        .live_bcd    (live_w),
        .disp_bcd    (disp_w),
        .frozen      (frozen_w),
        .sec_tick    (tick_w),
        .at_max      (at_max_w)
    );

    stopwatch_counter #(.TICK_DIV(TD), .WRAP_EN(1'b0)) u_sat (
        .clk         (clk),
        .reset       (reset),
        .count_en    (count_en),
        .count_reset (count_reset),
        .freeze_en   (freeze_en),
        .live_bcd    (live_s),
        .disp_bcd    (disp_s),
        .frozen      (frozen_s),
        .sec_tick    (tick_s),
        .at_max      (at_max_s)
    );

    int n_checks = 0;
    int n_pass   = 0;

    exp_t exp_w_q[$];
    exp_t exp_s_q[$];

    int          m_presc;
    int          m_secs [2];
    logic [15:0] m_disp [2];
    logic        m_frozen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic legal(input logic [15:0] v);
        return (v[15:12] <= 5) && (v[11:8] <= 9) && (v[7:4] <= 5) && (v[3:0] <= 9);
    endfunction

    task automatic model_step(input logic r, input logic cr, input logic en, input logic fz);
        logic t;
        t = 1'b0;
        if (r || cr) begin
            m_presc  = 0;
            m_secs   = '{0, 0};
            m_disp   = '{16'h0, 16'h0};
            m_frozen = r ? 1'b0 : fz;
        end else begin
            m_frozen = fz;
            if (en) begin
                if (m_presc == TD - 1) begin
                    m_presc = 0;
                    t = 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        if (m_secs[i] == 3599) m_secs[i] = (i == 0) ? 0 : 3599;
                        else m_secs[i] = m_secs[i] + 1;
                    end
                end else begin
                    m_presc = m_presc + 1;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!fz) m_disp[i] = to_bcd(m_secs[i]);
            end
        end
        exp_w_q.push_back('{to_bcd(m_secs[0]), m_disp[0], m_frozen, t, m_secs[0] == 3599});
        exp_s_q.push_back('{to_bcd(m_secs[1]), m_disp[1], m_frozen, t, m_secs[1] == 3599});
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (exp_w_q.size() == 0 || exp_s_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_w_q.pop_front();
        check("live_w",   live_w,   e.live);
        check("disp_w",   disp_w,   e.disp);
        check("frozen_w", frozen_w, e.frozen);
        check("tick_w",   tick_w,   e.tick);
        check("at_max_w", at_max_w, e.at_max);
        e = exp_s_q.pop_front();
        check("live_s",   live_s,   e.live);
        check("disp_s",   disp_s,   e.disp);
        check("frozen_s", frozen_s, e.frozen);
        check("tick_s",   tick_s,   e.tick);
        check("at_max_s", at_max_s, e.at_max);
        check("legal_w",  legal(live_w) && legal(disp_w), 1);
        check("legal_s",  legal(live_s) && legal(disp_s), 1);
    endtask

    task automatic cyc(input logic r, input logic cr, input logic en, input logic fz);
        @(negedge clk);
        reset       = r;
        count_reset = cr;
        count_en    = en;
        freeze_en   = fz;
        model_step(r, cr, en, fz);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    initial begin
        int guard;
        reset = 1'b1; count_en = 1'b0; count_reset = 1'b0; freeze_en = 1'b0;
        m_presc = 0; m_secs = '{0, 0}; m_disp = '{16'h0, 16'h0}; m_frozen = 1'b0;

        // 1: reset then free-running count
        repeat (2) cyc(1, 0, 0, 0);
        check("t1_reset_live", live_w, 16'h0000);
        repeat (40) cyc(0, 0, 1, 0);
        check("t1_live_10s", live_w, 16'h0010);

        // 2: run up to 59:59, then one more second on each build
        guard = 0;
        while (m_secs[0] != 3599 && guard < 20000) begin
            cyc(0, 0, 1, 0);
            guard++;
        end
        check("t2_preload_in_budget", guard < 20000, 1);
        check("t2_at_max_w", at_max_w, 1);
        check("t2_live_max", live_w, 16'h5959);
        repeat (TD) cyc(0, 0, 1, 0);
        check("t2_wrap_live", live_w, 16'h0000);
        check("t2_wrap_at_max", at_max_w, 0);
        check("t2_sat_live", live_s, 16'h5959);
        check("t2_sat_at_max", at_max_s, 1);

        // 3: lap freeze
        cyc(1, 0, 0, 0);
        repeat (7 * TD) cyc(0, 0, 1, 0);
        check("t3_live_7", live_w, 16'h0007);
        repeat (20) cyc(0, 0, 1, 1);
        check("t3_disp_held", disp_w, 16'h0007);
        check("t3_live_12", live_w, 16'h0012);
        check("t3_frozen", frozen_w, 1);
        cyc(0, 0, 1, 0);
        check("t3_disp_rejoin", disp_w, 16'h0012);

        // 4: pause at prescaler 2 keeps the partial second
        cyc(1, 0, 0, 0);
        repeat (2) cyc(0, 0, 1, 0);
        repeat (10) cyc(0, 0, 0, 0);
        check("t4_paused_live", live_w, 16'h0000);
        cyc(0, 0, 1, 0);
        check("t4_no_tick_yet", tick_w, 0);
        cyc(0, 0, 1, 0);
        check("t4_tick_after_2", tick_w, 1);
        check("t4_live_1", live_w, 16'h0001);

        // 5: count_reset during freeze at 01:35
        cyc(1, 0, 0, 0);
        repeat (95 * TD) cyc(0, 0, 1, 0);
        check("t5_live_0135", live_w, 16'h0135);
        repeat (2) cyc(0, 0, 1, 1);
        check("t5_disp_0135", disp_w, 16'h0135);
        cyc(0, 1, 1, 1);
        check("t5_live_clr", live_w, 16'h0000);
        check("t5_disp_clr", disp_w, 16'h0000);
        check("t5_frozen_kept", frozen_w, 1);
        repeat (TD) cyc(0, 0, 1, 0);
        check("t5_resume", live_w, 16'h0001);

        // 6: reset wins over a due tick and count_reset
        cyc(1, 0, 0, 0);
        repeat (TD - 1) cyc(0, 0, 1, 0);
        cyc(1, 1, 1, 1);
        check("t6_tick_suppressed", tick_w, 0);
        check("t6_live_zero", live_w, 16'h0000);
        check("t6_frozen_zero", frozen_w, 0);
        cyc(0, 0, 1, 0);
        check("t6_no_tick_after", tick_w, 0);

        // Random mix, scoreboard only
        for (int i = 0; i < 400; i++) begin
            cyc(1'b0, $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
